// File: rtl/prio_enc_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_arb_n
//  Description : Registered N-input priority encoder / arbiter with a
//                valid/ready result handshake. In IDLE, a non-zero request
//                vector sampled while en=1 is encoded into out_idx and held
//                in HOLD until out_ready consumes it. A consuming cycle can
//                capture a new result immediately, giving back-to-back
//                results.
//                Default build: fixed priority (highest set index wins).
//                Define PRIO_ENC_ARB_RR_EN for round-robin priority. In that
//                build the search starts at a rotating pointer and runs
//                downward with wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_arb_n #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic            busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic [IDXW-1:0] r_idx;

    logic            w_req_any;
    logic            w_slot_free;
    logic            w_capture;
    logic [IDXW-1:0] w_winner;

    // ------------------------------------------------------------------------
    // Fixed-priority search: the highest set index wins. The loop walks
    // upward so later (higher) hits overwrite earlier ones.
    // ------------------------------------------------------------------------
    function automatic logic [IDXW-1:0] f_fixed_winner(input logic [N-1:0] req_v);
        logic [IDXW-1:0] win;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (req_v[i]) begin
                win = IDXW'(i);
            end
        end
        return win;
    endfunction

    // Capture condition shared by both states. A slot is free when nothing is
    // pending, or when the pending result is being consumed this cycle.
    assign w_req_any   = |req;
    assign w_slot_free = (r_state == S_IDLE) || out_ready;
    assign w_capture   = en && w_req_any && w_slot_free;

`ifdef PRIO_ENC_ARB_RR_EN
    // ------------------------------------------------------------------------
    // Round-robin search: the order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1,
    // and the first set bit wins. The loop runs from the farthest offset
    // down to offset 0, so the hit closest to ptr is written last.
    // ------------------------------------------------------------------------
    function automatic logic [IDXW-1:0] f_rr_winner(input logic [N-1:0]    req_v,
                                                    input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] win;
        int              pos;
        win = '0;
        for (int j = N - 1; j >= 0; j--) begin
            pos = int'(ptr) - j;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (req_v[pos]) begin
                win = IDXW'(pos);
            end
        end
        return win;
    endfunction

    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_next;

    assign w_winner = f_rr_winner(req, r_ptr);

    // The pointer moves just below the index that was granted. Index 0
    // wraps to N-1.
    assign w_ptr_next = (w_winner == '0) ? IDXW'(N - 1) : (w_winner - IDXW'(1));

    // Rotation pointer: advances only on an actual capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDXW'(N - 1);
        end else if (w_capture) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    assign w_winner = f_fixed_winner(req);
`endif

    // Result FSM. State, valid and index are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_idx   <= w_winner;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Hold steady until consumed. While out_ready is high,
                    // refill in the same cycle or drop back to IDLE.
                    if (out_ready) begin
                        if (w_capture) begin
                            r_idx   <= w_winner;
                            r_valid <= 1'b1;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign busy      = (r_state == S_HOLD);

endmodule
`default_nettype wire
